// File: rtl/regfile_pkg.sv
// Shared defaults and the write-buffer entry layout for the buffered register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int NREGS_DEF = 16;
  localparam int DEPTH_DEF = 2;
  localparam int ADDR_W    = 4;

  // Register 15 is hardwired to zero: reads return 0, retires discard data.
  localparam logic [ADDR_W-1:0] ZERO_REG = 4'd15;

  // One pending write awaiting retirement into storage.
  typedef struct packed {
    logic                 valid;
    logic [ADDR_W-1:0]    addr;
    logic [WIDTH_DEF-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/mux16.sv
// 16:1 read-select multiplexer over the storage registers.
// Latency: combinational.
// Backpressure: none.
module mux16 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] in_i [16],
  input  logic [3:0]       sel_i,
  output logic [WIDTH-1:0] out_o
);

  // Plain indexed select.
  always_comb begin
    out_o = in_i[sel_i];
  end

endmodule

// File: rtl/reg64.sv
// Single storage register: loads d_i when en_i is high, cleared by async reset.
// Latency: one clock from en_i to q_o.
// Backpressure: none.
module reg64 #(
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] val_q;

  // Hold value unless enabled; clear asynchronously on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      val_q <= '0;
    end else if (en_i) begin
      val_q <= d_i;
    end
  end

  assign q_o = val_q;

endmodule

// File: rtl/regfile_wb.sv
// Register file with a small in-order write buffer; pending writes forward to reads.
// Latency: accepted write visible on reads next cycle; storage updated on the retire edge.
// Backpressure: wr_ready drops when the buffer is full, regardless of commit_en.
module regfile_wb
  import regfile_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         commit_en,
  input  logic [ADDR_W-1:0]            rd_addr_a,
  input  logic [ADDR_W-1:0]            rd_addr_b,
  output logic [WIDTH-1:0]             rd_data_a,
  output logic [WIDTH-1:0]             rd_data_b,
  output logic [$clog2(DEPTH+1)-1:0]   pend_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  wr_entry_t        ent_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept, retire;
  logic [NREGS-1:0] we_d;
  logic [WIDTH-1:0] wdata_d;
  logic [WIDTH-1:0] store [NREGS];
  logic [WIDTH-1:0] stor_a, stor_b, fwd_a, fwd_b;
  logic [PTR_W-1:0] age_idx [DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign wr_ready   = (cnt_q < CNT_W'(DEPTH));
  assign accept     = wr_valid && wr_ready;
  assign retire     = commit_en && (cnt_q != '0);
  assign pend_count = cnt_q;

  // Buffer pointers, occupancy and entry contents; pending entries vanish on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      // Head and tail differ whenever both fire, so the two writes never collide.
      if (retire) begin
        ent_q[head_q].valid <= 1'b0;
        head_q              <= ptr_inc(head_q);
      end
      if (accept) begin
        ent_q[tail_q] <= '{valid: 1'b1, addr: wr_addr, data: WIDTH_DEF'(wr_data)};
        tail_q        <= ptr_inc(tail_q);
      end
      case ({accept, retire})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Retire enable: head entry goes to its register unless it targets the zero register.
  always_comb begin
    we_d    = '0;
    wdata_d = WIDTH'(ent_q[head_q].data);
    if (retire && (ent_q[head_q].addr != ZERO_REG)) begin
      we_d[ent_q[head_q].addr] = 1'b1;
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_reg
    reg64 #(.WIDTH(WIDTH)) u_reg (
      .clk_i  (clk),
      .rst_ni (reset_n),
      .en_i   (we_d[g]),
      .d_i    (wdata_d),
      .q_o    (store[g])
    );
  end

  mux16 #(.WIDTH(WIDTH)) u_mux_a (.in_i(store), .sel_i(rd_addr_a), .out_o(stor_a));
  mux16 #(.WIDTH(WIDTH)) u_mux_b (.in_i(store), .sel_i(rd_addr_b), .out_o(stor_b));

  // Buffer slots listed oldest first, starting at the head.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      age_idx[k] = PTR_W'((int'(head_q) + k) % DEPTH);
    end
  end

  // Forwarding: walk oldest to youngest so the youngest match wins over storage.
  always_comb begin
    fwd_a = stor_a;
    fwd_b = stor_b;
    for (int k = 0; k < DEPTH; k++) begin
      if (ent_q[age_idx[k]].valid && (ent_q[age_idx[k]].addr == rd_addr_a))
        fwd_a = WIDTH'(ent_q[age_idx[k]].data);
      if (ent_q[age_idx[k]].valid && (ent_q[age_idx[k]].addr == rd_addr_b))
        fwd_b = WIDTH'(ent_q[age_idx[k]].data);
    end
    rd_data_a = (rd_addr_a == ZERO_REG) ? '0 : fwd_a;
    rd_data_b = (rd_addr_b == ZERO_REG) ? '0 : fwd_b;
  end

endmodule
